dither_fs_engine: RTL and testbench

Parametrised Floyd–Steinberg dithering draw engine: fills a rectangle of the frame store with a constant input colour, quantised to `OUT_BITS` per pixel, with the quantisation error optionally diffused to neighbouring pixels. It sits on the same command-register interface (`req`/`ack`, `r0`–`r7`) and frame-store write port (`de_*`) as the other drawing cells. It replaces the fixed 8→3-bit, 640-wide engine, adding parametrisation, a per-command mode select, rectangle validation and synchronous reset.

---
 rtl/dither_fs_engine.sv | 155 +++++++++++++++
 tb/tb_dither_fs_engine.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dither_fs_engine.sv
// dither_fs_engine: rectangle fill quantised to OUT_BITS with optional Floyd-Steinberg error diffusion
module dither_fs_engine #(
  parameter int SCREEN_W = 640,
  parameter int ADDR_W   = 18,
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              ack,
  output logic              busy,
  input  logic [15:0]       r0,
  input  logic [15:0]       r1,
  input  logic [15:0]       r2,
  input  logic [15:0]       r3,
  input  logic [15:0]       r4,
  input  logic [15:0]       r5,
  input  logic [15:0]       r6,
  input  logic [15:0]       r7,
  output logic              de_req,
  input  logic              de_ack,
  output logic [ADDR_W-1:0] de_addr,
  output logic [3:0]        de_nbyte,
  output logic              de_rnw,
  output logic [31:0]       de_w_data,
  input  logic [31:0]       de_r_data
);
  localparam int SH = IN_BITS - OUT_BITS;
  localparam int EW = SH + 5;
  localparam int XW = $clog2(SCREEN_W);
  localparam logic signed [15:0] S_HALF = 16'(1 << (SH - 1));
  localparam logic signed [15:0] S_VMAX = 16'((1 << IN_BITS) - 1);
  localparam logic signed [15:0] S_QMAX = 16'((1 << OUT_BITS) - 1);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_CALC, S_WRITE} state_t;
  state_t r_state, w_next;
  logic [15:0] r_xs, r_ys, r_xe, r_ye, r_x, r_y, r_cx;
  logic [IN_BITS-1:0] r_color;
  logic r_mode, r_ack;
  logic signed [EW-1:0] r_carry, r_b0, r_b1;
  logic signed [EW-1:0] r_err [SCREEN_W];
  logic [ADDR_W-1:0] r_addr;
  logic [3:0] r_nbyte;
  logic [31:0] r_data;
  logic w_valid, w_first, w_last_x, w_last;
  logic [XW-1:0] w_idx;
  logic signed [15:0] w_acc, w_inc, w_vr, w_v, w_qr, w_q, w_e;
  logic [7:0] w_byte;
  logic [31:0] w_baddr;
  logic [3:0] w_nbyte;
  logic w_unused;

  function automatic logic signed [15:0] sx(input logic signed [EW-1:0] a);
    return {{(16-EW){a[EW-1]}}, a};
  endfunction

  assign ack = r_ack;
  assign busy = r_state != S_IDLE;
  assign de_req = r_state == S_WRITE;
  assign de_rnw = 1'b0;
  assign de_addr = r_addr;
  assign de_nbyte = r_nbyte;
  assign de_w_data = r_data;
  assign w_unused = ^{r4[15:IN_BITS], r5[15:1], r6, r7, de_r_data, w_baddr[31:ADDR_W+2], w_q[15:OUT_BITS]};

  // pixel arithmetic: incoming error, clamp, quantise, residual error, address and lane select
  always_comb begin
    w_valid = !(r2 < r0) && !(r3 < r1) && (r2 < 16'(SCREEN_W));
    w_idx = r_x[XW-1:0];
    w_first = r_x == r_xs;
    w_last_x = r_x == r_xe;
    w_last = w_last_x && (r_y == r_ye);
    w_acc = r_mode ? sx(r_err[w_idx]) + (w_first ? 16'sd0 : sx(r_carry)) : 16'sd0;
    w_inc = (w_acc + 16'sd8) >>> 4;
    w_vr = $signed(16'(r_color)) + w_inc;
    w_v = (w_vr < 16'sd0) ? 16'sd0 : (w_vr > S_VMAX) ? S_VMAX : w_vr;
    w_qr = (w_v + S_HALF) >>> SH;
    w_q = (w_qr > S_QMAX) ? S_QMAX : w_qr;
    w_e = w_v - (w_q <<< SH);
    w_byte = {w_q[OUT_BITS-1:0], {(8-OUT_BITS){1'b0}}};
    w_baddr = 32'(r_y) * 32'(SCREEN_W) + 32'(r_x);
    w_nbyte = ~(4'b0001 << w_baddr[1:0]);
  end

  // next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (req && w_valid) ? S_CLEAR : S_IDLE;
      S_CLEAR: w_next = (r_cx == r_xe) ? S_CALC : S_CLEAR;
      S_CALC:  w_next = S_WRITE;
      S_WRITE: w_next = !de_ack ? S_WRITE : w_last ? S_IDLE : S_CALC;
      default: w_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // command latch, pixel walk, diffusion holding registers and write-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_addr <= '0;
      r_nbyte <= 4'hF;
      r_data <= '0;
      r_x <= '0;
      r_y <= '0;
      r_cx <= '0;
      r_carry <= '0;
      r_b0 <= '0;
      r_b1 <= '0;
    end else begin
      r_ack <= (r_state == S_IDLE) && req;
      if (r_state == S_IDLE && req) begin
        r_xs <= r0;
        r_ys <= r1;
        r_xe <= r2;
        r_ye <= r3;
        r_color <= r4[IN_BITS-1:0];
        r_mode <= r5[0];
        r_cx <= r0;
      end
      if (r_state == S_CLEAR) begin
        r_cx <= r_cx + 16'd1;
        if (r_cx == r_xe) begin
          r_x <= r_xs;
          r_y <= r_ys;
        end
      end
      if (r_state == S_CALC) begin
        r_addr <= w_baddr[ADDR_W+1:2];
        r_nbyte <= w_nbyte;
        r_data <= {4{w_byte}};
        r_carry <= EW'(w_e * 16'sd7);
        r_b0 <= EW'((w_first ? 16'sd0 : sx(r_b1)) + w_e * 16'sd5);
        r_b1 <= EW'(w_e);
      end
      if (r_state == S_WRITE && de_ack) begin
        r_x <= w_last_x ? r_xs : r_x + 16'd1;
        r_y <= w_last_x ? r_y + 16'd1 : r_y;
      end
    end
  end

  // error row buffer: clear span, retire the finished below-left entry, flush the row-end entry
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) r_err[r_cx[XW-1:0]] <= '0;
    else if (r_state == S_CALC && !w_first) r_err[w_idx - XW'(1)] <= EW'(sx(r_b0) + w_e * 16'sd3);
    else if (r_state == S_WRITE && de_ack && w_last_x) r_err[w_idx] <= r_b0;
  end
endmodule

// File: tb/tb_dither_fs_engine.sv
// tb_dither_fs_engine: randomized and directed checks of dither_fs_engine against a behavioural model
module tb_dither_fs_engine;
  localparam int SW = 640;
  localparam int AW = 18;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic [15:0] r0 = '0, r1 = '0, r2 = '0, r3 = '0, r4 = '0, r5 = '0, r6 = '0, r7 = '0;
  logic ack, busy, de_req, de_rnw;
  logic de_ack = 1'b0;
  logic [AW-1:0] de_addr;
  logic [3:0] de_nbyte;
  logic [31:0] de_w_data;
  logic [31:0] de_r_data = 32'hDEAD_BEEF;

  typedef struct {
    int baddr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int ack_mode = 0;
  int accepted = 0;
  bit p_valid = 1'b0;
  logic [AW-1:0] p_addr;
  logic [3:0] p_nb;
  logic [31:0] p_data;

  dither_fs_engine dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .busy(busy),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
    .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  function automatic int fl16(input int a);
    return (a >= 0) ? a / 16 : -((15 - a) / 16);
  endfunction

  task automatic model(input int xs, ys, xe, ye, col, mode, output wr_t out[$]);
    int acc [8][8];
    int dx[4] = '{1, -1, 0, 1};
    int dy[4] = '{0, 1, 1, 1};
    int wt[4] = '{7, 3, 5, 1};
    int v, q, e, tx, ty;
    wr_t w;
    out.delete();
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) acc[i][j] = 0;
    for (int y = ys; y <= ye; y++) begin
      for (int x = xs; x <= xe; x++) begin
        v = col + (mode != 0 ? fl16(acc[y-ys][x-xs] + 8) : 0);
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        q = (v + 16) / 32;
        if (q > 7) q = 7;
        e = v - q * 32;
        w.baddr = y * SW + x;
        w.data = {4{8'(q * 32)}};
        out.push_back(w);
        if (mode != 0) begin
          for (int k = 0; k < 4; k++) begin
            tx = x + dx[k];
            ty = y + dy[k];
            if (tx >= xs && tx <= xe && ty >= ys && ty <= ye) acc[ty-ys][tx-xs] += wt[k] * e;
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      de_ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  always @(negedge clk) begin : compare
    wr_t w;
    logic [3:0] nb;
    if (rst || !de_req) p_valid = 1'b0;
    else begin
      chk("rnw", de_rnw, 0);
      if (p_valid) begin
        chk("stall_addr", de_addr, p_addr);
        chk("stall_nbyte", de_nbyte, p_nb);
        chk("stall_data", de_w_data, p_data);
      end
      if (de_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual_addr=%0h required=no_write", de_addr);
        end else begin
          w = exp_q.pop_front();
          nb = 4'hF ^ (4'b0001 << (w.baddr % 4));
          chk("wr_addr", de_addr, w.baddr >> 2);
          chk("wr_nbyte", de_nbyte, nb);
          chk("wr_data", de_w_data, w.data);
        end
        accepted++;
        p_valid = 1'b0;
      end else begin
        p_addr = de_addr;
        p_nb = de_nbyte;
        p_data = de_w_data;
        p_valid = 1'b1;
      end
    end
  end

  task automatic issue(input int xs, ys, xe, ye, col, mode, output bit valid);
    wr_t t[$];
    valid = (xe >= xs) && (ye >= ys) && (xe < SW);
    if (valid) begin
      model(xs, ys, xe, ye, col, mode, t);
      foreach (t[i]) exp_q.push_back(t[i]);
    end
    @(posedge clk);
    #1;
    r0 = 16'(xs); r1 = 16'(ys); r2 = 16'(xe); r3 = 16'(ye);
    r4 = {8'($urandom), 8'(col)};
    r5 = {15'($urandom), 1'(mode)};
    r6 = 16'($urandom); r7 = 16'($urandom);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom);
    r3 = 16'($urandom); r4 = 16'($urandom); r5 = 16'($urandom);
    @(negedge clk);
    chk("ack_pulse", ack, 1);
    chk("busy_rise", busy, valid);
  endtask

  task automatic wait_done(input bit valid, input int exp_cycles);
    int cyc = 1;
    bit done = 1'b0;
    @(negedge clk);
    chk("ack_once", ack, 0);
    if (!valid) begin
      repeat (4) begin
        chk("invalid_busy", busy, 0);
        chk("invalid_de_req", de_req, 0);
        @(negedge clk);
      end
      return;
    end
    for (int k = 0; k < 5000 && !done; k++) begin
      if (!busy) done = 1'b1;
      else begin
        cyc++;
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=stuck required=idle_within_5000");
    end
    chk("de_req_end", de_req, 0);
    chk("queue_drained", exp_q.size(), 0);
    if (exp_cycles >= 0) chk("busy_cycles", cyc, exp_cycles);
    exp_q.delete();
  endtask

  task automatic run_cmd(input int xs, ys, xe, ye, col, mode);
    bit valid;
    int n;
    issue(xs, ys, xe, ye, col, mode, valid);
    n = (xe - xs + 1) * (ye - ys + 1);
    wait_done(valid, (ack_mode == 0) ? (xe - xs + 1) + 2 * n : -1);
  endtask

  initial begin : main
    wr_t t[$];
    bit valid;
    int base, xs, ys, xe, ye, w, h;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_de_req", de_req, 0);
    chk("rst_addr", de_addr, 0);
    chk("rst_nbyte", de_nbyte, 4'hF);
    chk("rst_data", de_w_data, 0);
    rst = 1'b0;
    ack_mode = 0;

    model(10, 2, 10, 2, 8'h50, 0, t);
    chk("pin_m0_addr", t[0].baddr, 1290);
    chk("pin_m0_data", t[0].data, 32'h60606060);
    run_cmd(10, 2, 10, 2, 8'h50, 0);

    model(33, 7, 33, 7, 8'hF8, 0, t);
    chk("pin_sat_data", t[0].data, 32'hE0E0E0E0);
    run_cmd(33, 7, 33, 7, 8'hF8, 0);

    model(0, 0, 3, 0, 8'h10, 1, t);
    chk("pin_row_d1", t[1].data, 32'h0);
    chk("pin_row_d2", t[2].data, 32'h20202020);
    chk("pin_row_d3", t[3].data, 32'h0);
    run_cmd(0, 0, 3, 0, 8'h10, 1);

    model(0, 0, 1, 1, 8'h10, 1, t);
    chk("pin_sq_a2", t[2].baddr, 640);
    chk("pin_sq_d2", t[2].data, 32'h0);
    chk("pin_sq_d3", t[3].data, 32'h20202020);
    ack_mode = 1;
    run_cmd(0, 0, 1, 1, 8'h10, 1);
    ack_mode = 0;

    run_cmd(9, 4, 5, 4, 8'h80, 1);
    run_cmd(5, 4, 9, 6, 8'h80, 1);

    base = accepted;
    issue(200, 5, 203, 7, 8'h37, 1, valid);
    for (int k = 0; k < 200 && accepted < base + 3; k++) @(negedge clk);
    ack_mode = 2;
    repeat (2) @(negedge clk);
    repeat (5) begin
      chk("stall_held", de_req, 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_de_req", de_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_nbyte", de_nbyte, 4'hF);
    chk("mid_rst_ack", ack, 0);
    rst = 1'b0;
    exp_q.delete();
    ack_mode = 0;
    run_cmd(200, 5, 203, 7, 8'h37, 1);

    for (int i = 0; i < 40; i++) begin
      ack_mode = $urandom_range(0, 1);
      w = $urandom_range(1, 8);
      h = $urandom_range(1, 5);
      xs = $urandom_range(0, SW - w);
      ys = $urandom_range(1, 400);
      case (i % 8)
        0: xs = SW - w;
        3: xs = 0;
        default: ;
      endcase
      xe = xs + w - 1;
      ye = ys + h - 1;
      if (i % 8 == 1) begin
        xs = SW - 2;
        xe = SW - 1 + $urandom_range(1, 4);
      end
      if (i % 8 == 2) ye = ys - 1;
      run_cmd(xs, ys, xe, ye, $urandom_range(0, 255), $urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end
endmodule
